// File: rtl/pixel_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_ctrl_pkg                                                             |
// | Shared types, default sizes and Gray-code helpers for the pixel readout.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pixel_ctrl_pkg;

    localparam int c_dw_def      = 8;
    localparam int c_n_pix_def   = 4;
    localparam int c_c_erase_def = 5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ERASE     = 3'd1,
        S_EXPOSE    = 3'd2,
        S_CONVERT   = 3'd3,
        S_RD_SETTLE = 3'd4,
        S_RD_CAPT   = 3'd5,
        S_RD_OUT    = 3'd6
    } state_t;

    // Operands are zero-extended to 32 bits so one helper serves any width up to 32.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_array_readout_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_array_readout_ctrl_if                                                |
// | Downstream pixel stream: data/index on a valid/ready handshake + done.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pixel_array_readout_ctrl_if #(
    parameter int DW    = pixel_ctrl_pkg::c_dw_def,
    parameter int N_PIX = pixel_ctrl_pkg::c_n_pix_def
);
    localparam int c_iw = (N_PIX > 1) ? $clog2(N_PIX) : 1;

    logic [DW-1:0]   pix_data;
    logic [c_iw-1:0] pix_idx;
    logic            pix_valid;
    logic            pix_ready;
    logic            frame_done;

    modport master (
        output pix_data,
        output pix_idx,
        output pix_valid,
        output frame_done,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_idx,
        input  pix_valid,
        input  frame_done,
        output pix_ready
    );

endinterface
`default_nettype wire

// File: rtl/pixel_adc_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_adc_counter                                                          |
// | Ramp-synchronous ADC count for the pixel buses; Gray-coded when            |
// | GRAY_COUNT_EN is defined, plain binary otherwise.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pixel_adc_counter
    import pixel_ctrl_pkg::*;
#(
    parameter int DW = c_dw_def
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          clr,
    input  wire logic          en,
    output logic [DW-1:0]      cnt_val,
    output logic               wrap
);

    logic [DW-1:0] r_bin;
    logic [DW-1:0] r_val;
    logic [DW-1:0] w_bin_nxt;
    logic [DW-1:0] w_val_nxt;

    assign w_bin_nxt = r_bin + 1'b1;

`ifdef GRAY_COUNT_EN
    assign w_val_nxt = DW'(bin2gray(32'(w_bin_nxt)));
`else
    assign w_val_nxt = w_bin_nxt;
`endif

    // Bus value is registered so the pixel latches never see encoder glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_val <= '0;
        end else if (clr) begin
            r_bin <= '0;
            r_val <= '0;
        end else if (en) begin
            r_bin <= w_bin_nxt;
            r_val <= w_val_nxt;
        end
    end

    assign cnt_val = r_val;
    assign wrap    = &r_bin;

endmodule
`default_nettype wire

// File: rtl/pixel_array_readout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_array_readout_ctrl                                                   |
// | Sequences ERASE -> EXPOSE -> CONVERT -> READ for the pixel array and       |
// | streams captured pixels downstream. Option: GRAY_COUNT_EN.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pixel_array_readout_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int DW      = c_dw_def,
    parameter int N_PIX   = c_n_pix_def,
    parameter int C_ERASE = c_c_erase_def
)(
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                start,
    input  wire logic [15:0]         expose_cycles,
    output logic                     erase,
    output logic                     expose,
    output logic [N_PIX-1:0]         read,
    output logic [DW-1:0]            cnt_val,
    output logic                     cnt_oe,
    input  wire logic [N_PIX*DW-1:0] data_in,
    output logic                     busy,
    pixel_array_readout_ctrl_if.master pix
);

    localparam int              c_iw         = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [15:0]     c_erase_last = 16'(C_ERASE - 1);
    localparam logic [c_iw-1:0] c_last_pix   = c_iw'(N_PIX - 1);

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_tmr;
    logic [15:0]     r_exp;
    logic [c_iw-1:0] r_k;
    logic [DW-1:0]   r_pix_data;
    logic [DW-1:0]   w_cap;
    logic [DW-1:0]   w_bus [N_PIX];
    logic            w_cnt_en;
    logic            w_wrap;
    logic            w_accept;
    logic            w_last;

    for (genvar gi = 0; gi < N_PIX; gi++) begin : g_bus
        assign w_bus[gi] = data_in[gi*DW +: DW];
    end

`ifdef GRAY_COUNT_EN
    assign w_cap = DW'(gray2bin(32'(w_bus[r_k])));
`else
    assign w_cap = w_bus[r_k];
`endif

    assign w_cnt_en = (r_state == S_CONVERT);
    assign w_last   = (r_k == c_last_pix);
    assign w_accept = (r_state == S_RD_OUT) && pix.pix_ready;

    pixel_adc_counter #(
        .DW (DW)
    ) u_adc_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!w_cnt_en),
        .en      (w_cnt_en),
        .cnt_val (cnt_val),
        .wrap    (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        erase          = 1'b0;
        expose         = 1'b0;
        cnt_oe         = 1'b0;
        read           = '0;
        pix.pix_valid  = 1'b0;
        pix.frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ERASE;
            end
            S_ERASE: begin
                erase = 1'b1;
                if (r_tmr == c_erase_last) w_next = S_EXPOSE;
            end
            S_EXPOSE: begin
                expose = 1'b1;
                if (r_tmr == r_exp - 16'd1) w_next = S_CONVERT;
            end
            S_CONVERT: begin
                cnt_oe = 1'b1;
                if (w_wrap) w_next = S_RD_SETTLE;
            end
            S_RD_SETTLE: begin
                read[r_k] = 1'b1;
                w_next    = S_RD_CAPT;
            end
            S_RD_CAPT: begin
                read[r_k] = 1'b1;
                w_next    = S_RD_OUT;
            end
            S_RD_OUT: begin
                pix.pix_valid = 1'b1;
                // Done pulses in the accept cycle, so a coincident START still sees a busy FSM.
                if (w_accept) begin
                    pix.frame_done = w_last;
                    w_next         = w_last ? S_IDLE : S_RD_SETTLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr      <= '0;
            r_exp      <= '0;
            r_k        <= '0;
            r_pix_data <= '0;
        end else begin
            // Phase timer restarts on every state change and idles outside timed phases.
            if ((w_next != r_state) || !(erase || expose)) begin
                r_tmr <= '0;
            end else begin
                r_tmr <= r_tmr + 16'd1;
            end
            if ((r_state == S_IDLE) && start) begin
                r_exp <= (expose_cycles == 16'd0) ? 16'd1 : expose_cycles;
                r_k   <= '0;
            end
            if (r_state == S_RD_CAPT) begin
                r_pix_data <= w_cap;
            end
            if (w_accept && !w_last) begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign pix.pix_data = r_pix_data;
    assign pix.pix_idx  = r_k;

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_readout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pixel_array_readout_ctrl                                                |
// | Randomized scoreboard bench for the pixel readout controller.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pixel_array_readout_ctrl;

    localparam int DW       = 8;
    localparam int N_PIX    = 4;
    localparam int C_ERASE  = 5;
    localparam int CONV_LEN = 256;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       expose_cycles = '0;
    logic              erase;
    logic              expose;
    logic [N_PIX-1:0]  read;
    logic [DW-1:0]     cnt_val;
    logic              cnt_oe;
    logic [N_PIX*DW-1:0] data_in = '0;
    logic              busy;

    pixel_array_readout_ctrl_if #(.DW(DW), .N_PIX(N_PIX)) pix ();

    pixel_array_readout_ctrl #(
        .DW      (DW),
        .N_PIX   (N_PIX),
        .C_ERASE (C_ERASE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .expose_cycles (expose_cycles),
        .erase         (erase),
        .expose        (expose),
        .read          (read),
        .cnt_val       (cnt_val),
        .cnt_oe        (cnt_oe),
        .data_in       (data_in),
        .busy          (busy),
        .pix           (pix)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   frames_done = 0;
    int   frames_exp = 0;
    exp_t sb_q[$];
    int   exp_len_q[$];
    bit   rand_ready = 1'b0;
    bit   stall_req = 1'b0;

    function automatic logic [7:0] enc(input logic [7:0] b);
`ifdef GRAY_COUNT_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Downstream sink: ready always, random, or a 20-cycle stall on pixel 1.
    initial begin : ready_drv
        int stall_left;
        stall_left = 0;
        pix.pix_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                pix.pix_ready = 1'b0;
                stall_left--;
            end else if (stall_req && pix.pix_valid && (pix.pix_idx == 2'd1)) begin
                pix.pix_ready = 1'b0;
                stall_left = 19;
                stall_req = 1'b0;
            end else if (rand_ready) begin
                pix.pix_ready = 1'($urandom_range(0, 1));
            end else begin
                pix.pix_ready = 1'b1;
            end
        end
    end

    // Monitor: phase lengths, ADC sequence, invariants, scoreboard pops.
    int         cyc = 0, erase_n = 0, expose_n = 0, conv_n = 0, rd_rise = 0;
    logic       p_erase = 0, p_expose = 0, p_oe = 0, p_valid = 0, p_ready = 0;
    logic [3:0] p_read = 0;
    logic [7:0] p_data = 0;
    logic [1:0] p_idx = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        logic exp_done;
        cyc++;
        if (!rst_n) begin
            erase_n = 0; expose_n = 0; conv_n = 0;
            p_erase = 0; p_expose = 0; p_oe = 0; p_valid = 0; p_ready = 0; p_read = 0;
        end else begin
            exp_done = 1'b0;
            chk("read_onehot", 32'($countones(read) <= 1), 1);
            chk("oe_overlap", 32'(cnt_oe && (read != 0 || erase || expose)), 0);
            if (pix.pix_valid) chk("read_while_valid", 32'(read), 0);

            if (erase) erase_n++;
            else if (p_erase) begin chk("erase_len", erase_n, C_ERASE); erase_n = 0; end

            if (expose) expose_n++;
            else if (p_expose) begin
                if (exp_len_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL expose_unexpected: got len %0d expected no exposure", expose_n);
                end else chk("expose_len", expose_n, exp_len_q.pop_front());
                expose_n = 0;
            end

            if (cnt_oe) begin
                chk("cnt_val", 32'(cnt_val), 32'(enc(8'(conv_n))));
                conv_n++;
            end else if (p_oe) begin
                chk("conv_len", conv_n, CONV_LEN);
                chk("cnt_val_zero", 32'(cnt_val), 0);
                conv_n = 0;
            end

            if (read != 0 && p_read == 0) begin
                rd_rise = cyc;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL read_unexpected: got read %0h expected none", read);
                end else chk("read_idx", 32'(read), 32'(4'b0001 << sb_q[0].idx));
            end
            if (pix.pix_valid && !p_valid) chk("read_to_valid", cyc - rd_rise, 2);

            if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(pix.pix_valid), 1);
                chk("hold_data", 32'(pix.pix_data), 32'(p_data));
                chk("hold_idx", 32'(pix.pix_idx), 32'(p_idx));
            end

            if (pix.pix_valid && pix.pix_ready) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_underflow: got pixel %0h expected none", pix.pix_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("pix_idx", 32'(pix.pix_idx), 32'(e.idx));
                    chk("pix_data", 32'(pix.pix_data), 32'(e.data));
                    exp_done = (e.idx == 2'(N_PIX - 1));
                end
            end
            chk("frame_done", 32'(pix.frame_done), 32'(exp_done));
            if (pix.frame_done) frames_done++;

            p_erase = erase; p_expose = expose; p_oe = cnt_oe; p_read = read;
            p_valid = pix.pix_valid; p_ready = pix.pix_ready;
            p_data = pix.pix_data; p_idx = pix.pix_idx;
        end
    end

    task automatic run_frame(input int e, input logic [31:0] vals, input bit noise,
                             input bit chk_len, input int extra);
        int   n;
        int   e_eff;
        bit   done;
        exp_t it;
        e_eff = (e == 0) ? 1 : e;
        @(posedge clk); #2;
        chk("idle_before_start", 32'(busy), 0);
        expose_cycles = 16'(e);
        for (int k = 0; k < N_PIX; k++) begin
            data_in[k*DW +: DW] = enc(vals[k*DW +: DW]);
            it.idx  = 2'(k);
            it.data = vals[k*DW +: DW];
            sb_q.push_back(it);
        end
        exp_len_q.push_back(e_eff);
        start = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 20000) begin
            @(posedge clk); #2;
            start = 1'b0;
            expose_cycles = 16'($urandom);
            n++;
            if (pix.frame_done) begin
                done = 1'b1;
                if (noise) start = 1'b1;
            end else begin
                chk("busy_in_frame", 32'(busy), 1);
                if (noise && (n == C_ERASE + 1 || n == C_ERASE + e_eff + CONV_LEN + 2))
                    start = 1'b1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL frame_timeout: got no frame_done after %0d cycles expected one", n);
        end else if (chk_len) begin
            chk("frame_len", n, C_ERASE + e_eff + CONV_LEN + 3 * N_PIX + extra);
        end
        frames_exp++;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 0);
        @(posedge clk); #2;
        chk("start_on_done_ignored", 32'(busy), 0);
        chk("frames_done", frames_done, frames_exp);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #2;
        chk("rst_erase", 32'(erase), 0);
        chk("rst_expose", 32'(expose), 0);
        chk("rst_read", 32'(read), 0);
        chk("rst_cnt_val", 32'(cnt_val), 0);
        chk("rst_cnt_oe", 32'(cnt_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(pix.pix_valid), 0);
        chk("rst_data", 32'(pix.pix_data), 0);
        chk("rst_frame_done", 32'(pix.frame_done), 0);
        @(negedge clk); rst_n = 1'b1;

        run_frame(10, 32'hFF807F00, 1'b0, 1'b1, 0);
        run_frame(0, $urandom, 1'b1, 1'b1, 0);
        stall_req = 1'b1;
        run_frame(int'($urandom_range(1, 30)), $urandom, 1'b0, 1'b1, 20);

        // Abort a frame in mid-conversion.
        @(posedge clk); #2;
        expose_cycles = 16'd3;
        exp_len_q.push_back(3);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        while (!cnt_oe && n < 100) begin @(posedge clk); #2; n++; end
        if (!cnt_oe) begin
            checks++; errors++;
            $display("FAIL convert_timeout: got cnt_oe 0 expected 1");
        end
        repeat (64) @(posedge clk); #2;
        chk("cnt_mid", 32'(cnt_val), 32'(enc(8'h40)));
        rst_n = 1'b0;
        #1;
        chk("arst_erase", 32'(erase), 0);
        chk("arst_expose", 32'(expose), 0);
        chk("arst_read", 32'(read), 0);
        chk("arst_cnt_val", 32'(cnt_val), 0);
        chk("arst_cnt_oe", 32'(cnt_oe), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(pix.pix_valid), 0);
        chk("arst_frame_done", 32'(pix.frame_done), 0);
        sb_q.delete();
        exp_len_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #2;
        chk("idle_after_reset", 32'(busy), 0);

        run_frame(int'($urandom_range(0, 40)), $urandom, 1'b0, 1'b1, 0);

        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(int'($urandom_range(0, 40)), $urandom, 1'b1, 1'b0, 0);
        end
        rand_ready = 1'b0;

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
